// File: rtl/can_frame_assembler.sv
// Collects UART bytes into a CAN frame (12-bit ID, DLC, up to 8 data bytes) and hands it
// to the CAN transmitter, double-buffered so the next frame assembles while the current one is sent.
module can_frame_assembler #(
    parameter int GAP_CYCLES   = 16,
    parameter int BYTE_TIMEOUT = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        statev,
    output logic [11:0] Can_ID_Bus,
    output logic [63:0] can_tx_data_bus,
    output logic        Frame_ready,
    output logic        Load_frame_datareg,
    output logic        T_frame,
    output logic        asm_busy,
    output logic        frame_err
);

    localparam logic [1:0] A_ID_HI = 2'd0;
    localparam logic [1:0] A_ID_LO = 2'd1;
    localparam logic [1:0] A_DLC   = 2'd2;
    localparam logic [1:0] A_DATA  = 2'd3;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_OFFER = 2'd1;
    localparam logic [1:0] T_GAP   = 2'd2;
    localparam logic [1:0] T_RUN   = 2'd3;

    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic          statev_q_r;
    logic          tog_s;
    logic          xfer_s;
    logic [1:0]    a_state_r;
    logic [11:0]   asm_id_r;
    logic [63:0]   asm_data_r;
    logic [3:0]    dlc_r;
    logic [3:0]    cnt_r;
    logic          asm_full_r;
    logic [TW-1:0] tmo_r;
    logic [1:0]    t_state_r;
    logic [GW-1:0] gap_r;
    logic [1:0]    run_cnt_r;

    assign tog_s  = statev ^ statev_q_r;
    assign xfer_s = asm_full_r && (t_state_r == T_IDLE);

    // Assembly FSM, inter-byte timeout, assembly buffer and error pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            a_state_r  <= A_ID_HI;
            asm_busy   <= 1'b0;
            asm_id_r   <= 12'h000;
            asm_data_r <= 64'h0;
            dlc_r      <= 4'd0;
            cnt_r      <= 4'd0;
            asm_full_r <= 1'b0;
            tmo_r      <= {TW{1'b0}};
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // A completing frame below overrides this clear (last assignment wins)
            if (xfer_s) begin
                asm_full_r <= 1'b0;
            end else begin
                asm_full_r <= asm_full_r;
            end
            if (rx_valid) begin
                tmo_r <= {TW{1'b0}};
                case (a_state_r)
                    A_ID_HI: begin
                        if (asm_full_r) begin
                            frame_err <= 1'b1;
                        end else begin
                            asm_id_r[11:8] <= rx_data[3:0];
                            a_state_r      <= A_ID_LO;
                            asm_busy       <= 1'b1;
                        end
                    end
                    A_ID_LO: begin
                        asm_id_r[7:0] <= rx_data;
                        a_state_r     <= A_DLC;
                    end
                    A_DLC: begin
                        if (rx_data > 8'd8) begin
                            frame_err <= 1'b1;
                            a_state_r <= A_ID_HI;
                            asm_busy  <= 1'b0;
                        end else begin
                            asm_data_r <= 64'h0;
                            cnt_r      <= 4'd0;
                            dlc_r      <= rx_data[3:0];
                            if (rx_data == 8'd0) begin
                                asm_full_r <= 1'b1;
                                a_state_r  <= A_ID_HI;
                                asm_busy   <= 1'b0;
                            end else begin
                                a_state_r <= A_DATA;
                            end
                        end
                    end
                    A_DATA: begin
                        asm_data_r[{cnt_r[2:0], 3'b000} +: 8] <= rx_data;
                        cnt_r <= cnt_r + 4'd1;
                        if ((cnt_r + 4'd1) == dlc_r) begin
                            asm_full_r <= 1'b1;
                            a_state_r  <= A_ID_HI;
                            asm_busy   <= 1'b0;
                        end else begin
                            a_state_r <= A_DATA;
                        end
                    end
                    default: begin
                        a_state_r <= A_ID_HI;
                        asm_busy  <= 1'b0;
                    end
                endcase
            end else if (a_state_r != A_ID_HI) begin
                if (tmo_r == TMO_LAST) begin
                    frame_err <= 1'b1;
                    a_state_r <= A_ID_HI;
                    asm_busy  <= 1'b0;
                    tmo_r     <= {TW{1'b0}};
                end else begin
                    tmo_r <= tmo_r + 1'b1;
                end
            end else begin
                tmo_r <= {TW{1'b0}};
            end
        end
    end

    // Output FSM: offer frame, wait for load-accept toggle, interframe gap, track transmission
    always_ff @(posedge clock) begin
        if (!reset) begin
            statev_q_r         <= statev;
            t_state_r          <= T_IDLE;
            gap_r              <= {GW{1'b0}};
            run_cnt_r          <= 2'd0;
            Can_ID_Bus         <= 12'h000;
            can_tx_data_bus    <= 64'h0;
            Frame_ready        <= 1'b0;
            Load_frame_datareg <= 1'b0;
            T_frame            <= 1'b0;
        end else begin
            statev_q_r <= statev;
            T_frame    <= 1'b0;
            case (t_state_r)
                T_IDLE: begin
                    if (xfer_s) begin
                        Can_ID_Bus         <= asm_id_r;
                        can_tx_data_bus    <= asm_data_r;
                        Frame_ready        <= 1'b1;
                        Load_frame_datareg <= 1'b1;
                        t_state_r          <= T_OFFER;
                    end else begin
                        t_state_r <= T_IDLE;
                    end
                end
                T_OFFER: begin
                    if (tog_s) begin
                        Frame_ready        <= 1'b0;
                        Load_frame_datareg <= 1'b0;
                        gap_r              <= {GW{1'b0}};
                        t_state_r          <= T_GAP;
                    end else begin
                        t_state_r <= T_OFFER;
                    end
                end
                T_GAP: begin
                    if (gap_r == GAP_LAST) begin
                        T_frame   <= 1'b1;
                        run_cnt_r <= 2'd0;
                        t_state_r <= T_RUN;
                    end else begin
                        gap_r <= gap_r + 1'b1;
                    end
                end
                T_RUN: begin
                    // START->TRANSMIT, TRANSMIT->STOP, STOP->IDLE: third toggle ends the frame
                    if (tog_s) begin
                        if (run_cnt_r == 2'd2) begin
                            t_state_r <= T_IDLE;
                        end else begin
                            run_cnt_r <= run_cnt_r + 2'd1;
                        end
                    end else begin
                        t_state_r <= T_RUN;
                    end
                end
                default: begin
                    t_state_r <= T_IDLE;
                end
            endcase
        end
    end

endmodule
